text_buffer: RTL and testbench

TEXT_BUFFER -- requirements
Module: text_buffer

---
 rtl/text_mode_pkg.sv | 17 +
 rtl/text_buffer_char_ram.sv | 26 ++
 rtl/text_buffer.sv | 144 ++++++++++++++
 tb/tb_text_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_mode_pkg.sv
// text_mode_pkg: shared constants and state type for the text-mode cell buffer.
// Holds the cell grid size, the blank fill value and the IDLE/CLEAR state encoding.
package text_mode_pkg;

   localparam int COLUMNS = 80;
   localparam int ROWS    = 30;
   localparam int CELLS   = COLUMNS * ROWS;

   localparam logic [7:0] BLANK_CODEPOINT = 8'h20;
   localparam logic [7:0] BLANK_ATTRIBUTE = 8'h07;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/text_buffer_char_ram.sv
// char_ram: simple dual-port cell storage, one write port and one registered read port.
// Ports: clk, we/wr_addr/wr_data (write), rd_addr in, rd_data out one cycle later (read-first).
module char_ram #(
   parameter int DEPTH = 2400,
   parameter int AW    = 12,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // No reset on the array or read register so the tools can map it to block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character cell store with a 2-cycle pixel read path and a blank-fill engine.
// Ports: clk_pixel/reset; cx/cy -> codepoint/attribute/cx_out/cy_out; wr_* host write; clear_req/busy.
module text_buffer #(
   parameter int BIT_WIDTH   = 12,
   parameter int BIT_HEIGHT  = 11,
   parameter int FONT_WIDTH  = 8,
   parameter int FONT_HEIGHT = 16,
   parameter int COLUMNS     = 80,
   parameter int ROWS        = 30
) (
   input  logic                  clk_pixel,
   input  logic                  reset,
   input  logic [BIT_WIDTH-1:0]  cx,
   input  logic [BIT_HEIGHT-1:0] cy,
   output logic [7:0]            codepoint,
   output logic [7:0]            attribute,
   output logic [BIT_WIDTH-1:0]  cx_out,
   output logic [BIT_HEIGHT-1:0] cy_out,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [6:0]            wr_col,
   input  logic [4:0]            wr_row,
   input  logic [7:0]            wr_codepoint,
   input  logic [7:0]            wr_attribute,
   output logic                  wr_dropped,
   input  logic                  clear_req,
   output logic                  busy
);

   import text_mode_pkg::*;

   localparam int CELLS = COLUMNS * ROWS;
   localparam int AW    = $clog2(CELLS);
   localparam int FW_SH = $clog2(FONT_WIDTH);
   localparam int FH_SH = $clog2(FONT_HEIGHT);
   localparam logic [AW-1:0] CLR_LAST = AW'(CELLS - 1);

   state_t state, state_next;
   logic [AW-1:0] clr_cnt, clr_next;

   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [15:0]   ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [15:0]   rd_data;

   logic                 host_ok;
   logic [AW-1:0]        host_addr;
   logic [BIT_WIDTH-FW_SH-1:0]  rd_col;
   logic [BIT_HEIGHT-FH_SH-1:0] rd_row;
   logic                 rd_ok;

   logic                  in_d1;
   logic [BIT_WIDTH-1:0]  cx_d1;
   logic [BIT_HEIGHT-1:0] cy_d1;

   assign host_ok   = (int'(wr_col) < COLUMNS) && (int'(wr_row) < ROWS);
   assign host_addr = AW'(wr_row) * AW'(COLUMNS) + AW'(wr_col);

   assign rd_col = cx[BIT_WIDTH-1:FW_SH];
   assign rd_row = cy[BIT_HEIGHT-1:FH_SH];
   assign rd_ok  = (int'(rd_col) < COLUMNS) && (int'(rd_row) < ROWS);

   // Off-grid pixels read address 0; their data is masked in the output stage.
   assign ram_raddr = rd_ok ? (AW'(rd_row) * AW'(COLUMNS) + AW'(rd_col)) : '0;

   always_comb begin
      state_next = state;
      clr_next   = '0;
      ram_we     = 1'b0;
      ram_waddr  = host_addr;
      ram_wdata  = {wr_attribute, wr_codepoint};
      wr_ready   = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE: begin
            wr_ready = 1'b1;
            ram_we   = wr_valid && host_ok;
            if (clear_req) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            busy      = 1'b1;
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = {BLANK_ATTRIBUTE, BLANK_CODEPOINT};
            if (clr_cnt == CLR_LAST) begin
               state_next = IDLE;
            end else begin
               clr_next = clr_cnt + AW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         wr_dropped <= 1'b0;
      end else begin
         state      <= state_next;
         clr_cnt    <= clr_next;
         wr_dropped <= (state == IDLE) && wr_valid && !host_ok;
      end
   end

   char_ram #(
      .DEPTH (CELLS),
      .AW    (AW),
      .DW    (16)
   ) u_ram (
      .clk     (clk_pixel),
      .we      (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_addr (ram_raddr),
      .rd_data (rd_data)
   );

   // Stage 1 runs alongside the RAM read register; stage 2 masks and registers outputs.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         in_d1     <= 1'b0;
         cx_d1     <= '0;
         cy_d1     <= '0;
         cx_out    <= '0;
         cy_out    <= '0;
         codepoint <= 8'h00;
         attribute <= 8'h00;
      end else begin
         in_d1     <= rd_ok;
         cx_d1     <= cx;
         cy_d1     <= cy;
         cx_out    <= cx_d1;
         cy_out    <= cy_d1;
         codepoint <= in_d1 ? rd_data[7:0]  : 8'h00;
         attribute <= in_d1 ? rd_data[15:8] : 8'h00;
      end
   end

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: randomized scoreboard bench for text_buffer.
// A cell-array model predicts pixel reads and dropped-write pulses; a monitor compares.
module tb_text_buffer;

   localparam int COLS  = 80;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;
   localparam logic [15:0] BLANK = 16'h0720;

   logic        clk_pixel = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] cx = '0;
   logic [10:0] cy = '0;
   logic [7:0]  codepoint, attribute;
   logic [11:0] cx_out;
   logic [10:0] cy_out;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [6:0]  wr_col = '0;
   logic [4:0]  wr_row = '0;
   logic [7:0]  wr_codepoint = '0;
   logic [7:0]  wr_attribute = '0;
   logic        wr_dropped;
   logic        clear_req = 1'b0;
   logic        busy;

   text_buffer dut (
      .clk_pixel    (clk_pixel),
      .reset        (reset),
      .cx           (cx),
      .cy           (cy),
      .codepoint    (codepoint),
      .attribute    (attribute),
      .cx_out       (cx_out),
      .cy_out       (cy_out),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_col       (wr_col),
      .wr_row       (wr_row),
      .wr_codepoint (wr_codepoint),
      .wr_attribute (wr_attribute),
      .wr_dropped   (wr_dropped),
      .clear_req    (clear_req),
      .busy         (busy)
   );

   always #5 clk_pixel = ~clk_pixel;

   typedef struct {
      int          due;
      logic [7:0]  cp;
      logic [7:0]  at;
      logic [11:0] x;
      logic [10:0] y;
   } pix_t;

   typedef struct {
      int   due;
      logic drop;
   } drop_t;

   pix_t  pix_q[$];
   drop_t drop_q[$];
   logic [15:0] model [CELLS];
   int edges = 0;
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_read(int x, int y);
      int c, r;
      c = x / 8;
      r = y / 16;
      if (c >= COLS || r >= ROWS) return 16'h0000;
      return model[r * COLS + c];
   endfunction

   task automatic model_write(int c, int r, logic [7:0] cp, logic [7:0] at);
      if (c < COLS && r < ROWS) model[r * COLS + c] = {at, cp};
   endtask

   task automatic model_clear();
      for (int i = 0; i < CELLS; i++) model[i] = BLANK;
   endtask

   task automatic step();
      @(posedge clk_pixel);
      #1;
   endtask

   // One tracked idle-state cycle: read pixel (x,y), optional host write.
   task automatic cycle(int x, int y, bit wv, int c, int r,
                        logic [7:0] cp, logic [7:0] at);
      pix_t  p;
      drop_t d;
      logic [15:0] e;
      cx = 12'(x);
      cy = 11'(y);
      wr_valid = wv;
      wr_col = 7'(c);
      wr_row = 5'(r);
      wr_codepoint = cp;
      wr_attribute = at;
      e = model_read(x, y);
      p.due = edges + 2;
      p.cp = e[7:0];
      p.at = e[15:8];
      p.x = 12'(x);
      p.y = 11'(y);
      pix_q.push_back(p);
      d.due = edges + 1;
      d.drop = wv && (c >= COLS || r >= ROWS);
      drop_q.push_back(d);
      if (wv) model_write(c, r, cp, at);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic wait_ready(input string name, int pulse_at);
      int n;
      bit early;
      n = 0;
      early = 0;
      while (!wr_ready && n < 5000) begin
         if (!busy) early = 1;
         clear_req = (n == pulse_at);
         step();
         n++;
      end
      clear_req = 1'b0;
      check(name, n, 2400);
      check({name, "_busy_gap"}, 32'(early), 0);
      check({name, "_busy_end"}, 32'(busy), 0);
   endtask

   initial begin : monitor
      pix_t  p;
      drop_t d;
      forever begin
         @(posedge clk_pixel);
         edges++;
         #1;
         while (pix_q.size() != 0 && pix_q[0].due <= edges) begin
            p = pix_q.pop_front();
            check("pix_due", p.due, edges);
            check("codepoint", codepoint, p.cp);
            check("attribute", attribute, p.at);
            check("cx_out", cx_out, p.x);
            check("cy_out", cy_out, p.y);
         end
         while (drop_q.size() != 0 && drop_q[0].due <= edges) begin
            d = drop_q.pop_front();
            check("drop_due", d.due, edges);
            check("wr_dropped", wr_dropped, d.drop);
         end
      end
   end

   initial begin : stim
      int x, y, c, r;
      bit wv;
      #1 reset = 1'b1;
      #3;
      check("rst_codepoint", codepoint, 0);
      check("rst_attribute", attribute, 0);
      check("rst_cx_out", cx_out, 0);
      check("rst_cy_out", cy_out, 0);
      check("rst_dropped", wr_dropped, 0);
      check("rst_busy", busy, 1);
      check("rst_ready", wr_ready, 0);
      cx = 12'd100;
      cy = 11'd37;
      repeat (3) step();
      check("rst_hold_cx_out", cx_out, 0);
      check("rst_hold_cy_out", cy_out, 0);
      reset = 1'b0;
      wait_ready("reset_clear_len", -1);
      model_clear();

      for (int rr = 0; rr < ROWS; rr++)
         for (int cc = 0; cc < COLS; cc++)
            cycle(cc * 8 + int'($urandom_range(0, 7)),
                  rr * 16 + int'($urandom_range(0, 15)), 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 5, 2, 8'h41, 8'h1F);
      for (int i = 40; i < 48; i++) cycle(i, 32 + (i - 40), 0, 0, 0, 0, 0);

      cycle(80, 48, 1, 10, 3, 8'hAA, 8'h55);
      cycle(85, 50, 0, 0, 0, 0, 0);

      cycle(640, 0, 0, 0, 0, 0, 0);
      cycle(0, 480, 0, 0, 0, 0, 0);
      cycle(4095, 2047, 0, 0, 0, 0, 0);
      cycle(639, 479, 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 80, 0, 8'hEE, 8'hEE);
      cycle(0, 16, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 3, 30, 8'hDD, 8'hDD);
      cycle(24, 480, 0, 0, 0, 0, 0);
      cycle(0, 16, 0, 0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         wv = 1'($urandom_range(0, 1));
         c = int'($urandom_range(0, 85));
         r = int'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            x = c * 8;
            y = r * 16;
         end else begin
            x = int'($urandom_range(0, 700));
            y = int'($urandom_range(0, 520));
         end
         cycle(x, y, wv, c, r, 8'($urandom), 8'($urandom));
      end
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

      wr_valid = 1'b1;
      wr_col = 7'd1;
      wr_row = 5'd1;
      wr_codepoint = 8'h55;
      wr_attribute = 8'h33;
      clear_req = 1'b1;
      step();
      wr_valid = 1'b0;
      clear_req = 1'b0;
      check("clear_start_busy", busy, 1);
      check("clear_start_ready", wr_ready, 0);
      wait_ready("clear_len", 100);
      model_clear();
      cycle(8, 16, 0, 0, 0, 0, 0);
      cycle(40, 32, 0, 0, 0, 0, 0);
      cycle(639, 479, 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 7, 7, 8'h99, 8'h88);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (1000) step();
      reset = 1'b1;
      #1;
      check("midrst_busy", busy, 1);
      check("midrst_ready", wr_ready, 0);
      check("midrst_codepoint", codepoint, 0);
      repeat (2) step();
      reset = 1'b0;
      wait_ready("midrst_clear_len", -1);
      model_clear();
      for (int cc = 0; cc < COLS; cc++) cycle(cc * 8, 7 * 16, 0, 0, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

      repeat (4) step();
      check("pix_q_drained", pix_q.size(), 0);
      check("drop_q_drained", drop_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
